// File: rtl/main_mem_ctrl.sv
// main_mem_ctrl: slow backing store behind the cache control FSM.
// One outstanding access; MStrobe accepted in IDLE only, completion after
// WAIT_CYCLES wait states plus one DONE cycle carrying the MReady pulse.
// Optional feature macro: MEM_STATS_EN adds saturating RdCount/WrCount outputs.
module main_mem_ctrl #(
   parameter int ADDR_W      = 8,
   parameter int DATA_W      = 32,
   parameter int DEPTH       = 256,
   parameter int WAIT_CYCLES = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              MStrobe,
   input  logic              MRW,
   input  logic [ADDR_W-1:0] MAddr,
   input  logic [DATA_W-1:0] MDataIn,
   output logic [DATA_W-1:0] MDataOut,
   output logic              MReady,
   output logic              MBusy
`ifdef MEM_STATS_EN
   ,
   output logic [15:0]       RdCount,
   output logic [15:0]       WrCount
`endif
);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

   localparam int        IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [7:0] CNT_LOAD = 8'(WAIT_CYCLES - 1);

   state_t              state_q, state_d;
   logic [7:0]          cnt_q, cnt_d;
   logic                rw_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [DATA_W-1:0]   din_q;
   logic [DATA_W-1:0]   dout_q;
   logic                accept, commit, in_range;
   logic [DATA_W-1:0]   rd_word;

   logic [DATA_W-1:0]   mem [DEPTH];

   // Out-of-range addresses never touch the array: writes drop, reads give 0.
   assign in_range = int'(addr_q) < DEPTH;
   assign rd_word  = in_range ? mem[addr_q[IDX_W-1:0]] : '0;

   // Next-state: accept in IDLE, count down wait states, commit on the last one.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      accept  = 1'b0;
      commit  = 1'b0;
      case (state_q)
         S_IDLE: if (MStrobe) begin
            accept  = 1'b1;
            cnt_d   = CNT_LOAD;
            state_d = S_WAIT;
         end
         S_WAIT: if (cnt_q != 8'd0) begin
            cnt_d = cnt_q - 8'd1;
         end else begin
            commit  = 1'b1;
            state_d = S_DONE;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // State, wait counter, request latch and read-data register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         rw_q    <= 1'b0;
         addr_q  <= '0;
         din_q   <= '0;
         dout_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (accept) begin
            rw_q   <= MRW;
            addr_q <= MAddr;
            din_q  <= MDataIn;
         end
         if (commit && !rw_q) dout_q <= rd_word;
      end
   end

   // Array write on commit; reset at the commit edge suppresses it. Contents survive reset.
   always_ff @(posedge clk) begin
      if (commit && rw_q && in_range && !reset) mem[addr_q[IDX_W-1:0]] <= din_q;
   end

   assign MDataOut = dout_q;
   assign MReady   = (state_q == S_DONE);
   assign MBusy    = (state_q != S_IDLE);

`ifdef MEM_STATS_EN
   logic [15:0] rd_cnt_q, wr_cnt_q;

   // Saturating access counters, bumped at the commit edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_cnt_q <= '0;
         wr_cnt_q <= '0;
      end else if (commit) begin
         if (!rw_q && rd_cnt_q != 16'hFFFF) rd_cnt_q <= rd_cnt_q + 16'd1;
         if (rw_q  && wr_cnt_q != 16'hFFFF) wr_cnt_q <= wr_cnt_q + 16'd1;
      end
   end

   assign RdCount = rd_cnt_q;
   assign WrCount = wr_cnt_q;
`endif

endmodule

// File: tb/tb_main_mem_ctrl.sv
// Directed bench for main_mem_ctrl (DEPTH reduced to 128 to reach the
// out-of-range path). Samples 1 time unit after each rising edge.
module tb_main_mem_ctrl;
   localparam int W = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        MStrobe = 1'b0;
   logic        MRW = 1'b0;
   logic [7:0]  MAddr = '0;
   logic [31:0] MDataIn = '0;
   logic [31:0] MDataOut;
   logic        MReady, MBusy;
`ifdef MEM_STATS_EN
   logic [15:0] RdCount, WrCount;
`endif

   int nvec = 0;
   int nerr = 0;
   logic [31:0] dout_m = '0;

   always #5 clk = ~clk;

   main_mem_ctrl #(.ADDR_W(8), .DATA_W(32), .DEPTH(128), .WAIT_CYCLES(W)) dut (
      .clk(clk), .reset(reset), .MStrobe(MStrobe), .MRW(MRW), .MAddr(MAddr),
      .MDataIn(MDataIn), .MDataOut(MDataOut), .MReady(MReady), .MBusy(MBusy)
`ifdef MEM_STATS_EN
      , .RdCount(RdCount), .WrCount(WrCount)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nvec++;
      if (obs !== exp) begin
         nerr++;
         $display("FAIL %s: got %h want %h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk); #1;
   endtask

   // One access from IDLE. poke_k >= 0 re-strobes a write of 1 during that busy sample.
   task automatic acc(input logic rw, input logic [7:0] a, input logic [31:0] d,
                      input logic [31:0] exp_rd, input int poke_k);
      MStrobe = 1'b1; MRW = rw; MAddr = a; MDataIn = d;
      tick();
      MStrobe = 1'b0;
      for (int k = 0; k <= W; k++) begin
         if (k == W && !rw) dout_m = exp_rd;
         chk("busy", 32'(MBusy), 32'd1);
         chk("ready", 32'(MReady), 32'(k == W));
         chk("dout", MDataOut, dout_m);
         if (k == poke_k) begin
            MStrobe = 1'b1; MRW = 1'b1; MAddr = a; MDataIn = 32'h1;
         end else begin
            MStrobe = 1'b0;
         end
         tick();
      end
      MStrobe = 1'b0;
      chk("idle_ready", 32'(MReady), 32'd0);
      chk("idle_busy", 32'(MBusy), 32'd0);
   endtask

   initial begin
      // 1 reset
      reset = 1'b1;
      tick(); tick();
      chk("rst_ready", 32'(MReady), 32'd0);
      chk("rst_busy", 32'(MBusy), 32'd0);
      chk("rst_dout", MDataOut, 32'd0);
      reset = 1'b0;
      tick();
      chk("post_rst_busy", 32'(MBusy), 32'd0);

      // 2 write, 3 read-back and hold
      acc(1'b1, 8'h10, 32'hDEADBEEF, 32'h0, -1);
      chk("wr_dout", MDataOut, 32'h0);
      acc(1'b0, 8'h10, 32'h0, 32'hDEADBEEF, -1);
      tick(); tick(); tick();
      chk("rd_hold", MDataOut, 32'hDEADBEEF);

      // 4 strobe during busy is ignored
      acc(1'b0, 8'h10, 32'h0, 32'hDEADBEEF, 1);
      tick();
      chk("ign_busy", 32'(MBusy), 32'd0);
      acc(1'b0, 8'h10, 32'h0, 32'hDEADBEEF, -1);

      // 5 reset before the commit edge aborts the write
      MStrobe = 1'b1; MRW = 1'b1; MAddr = 8'h10; MDataIn = 32'hCAFEF00D;
      tick();
      MStrobe = 1'b0;
      tick(); tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      dout_m = 32'h0;
      chk("abort_busy", 32'(MBusy), 32'd0);
      chk("abort_dout", MDataOut, 32'h0);
      for (int i = 0; i < 4; i++) begin
         chk("abort_ready", 32'(MReady), 32'd0);
         tick();
      end
      acc(1'b0, 8'h10, 32'h0, 32'hDEADBEEF, -1);

      // boundary: last word, out-of-range write dropped (no aliasing), read gives 0
      acc(1'b1, 8'h7F, 32'h0BADF00D, 32'h0, -1);
      acc(1'b1, 8'h70, 32'h5555AAAA, 32'h0, -1);
      acc(1'b1, 8'hF0, 32'h12345678, 32'h0, -1);
      acc(1'b0, 8'h7F, 32'h0, 32'h0BADF00D, -1);
      acc(1'b0, 8'h70, 32'h0, 32'h5555AAAA, -1);
      acc(1'b0, 8'hF0, 32'h0, 32'h0, -1);

`ifdef MEM_STATS_EN
      // 6 counters
      reset = 1'b1; tick(); reset = 1'b0; dout_m = 32'h0;
      chk("st_rd0", 32'(RdCount), 32'd0);
      chk("st_wr0", 32'(WrCount), 32'd0);
      acc(1'b1, 8'h01, 32'h11, 32'h0, -1);
      acc(1'b1, 8'h02, 32'h22, 32'h0, -1);
      acc(1'b1, 8'h03, 32'h33, 32'h0, -1);
      acc(1'b0, 8'h01, 32'h0, 32'h11, -1);
      acc(1'b0, 8'h03, 32'h0, 32'h33, -1);
      chk("st_wr", 32'(WrCount), 32'd3);
      chk("st_rd", 32'(RdCount), 32'd2);
      reset = 1'b1; tick(); reset = 1'b0;
      chk("st_rd_rst", 32'(RdCount), 32'd0);
      chk("st_wr_rst", 32'(WrCount), 32'd0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
